prog_run_sequencer: RTL and testbench

//  Synthesizable batch launcher for the basic processor: drives DUT Reset/Start, waits for Ack, records cycles per run.

---
 rtl/seq_pkg.sv | 12 +
 rtl/sat_counter.sv | 33 +++
 rtl/prog_run_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_prog_run_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the program-run sequencer: FSM state encoding and the
// width helper used for program-index and phase-counter buses.
package seq_pkg;

    typedef enum logic [1:0] {IDLE, RST_HOLD, START, WAIT} seq_state_t;

    // Bus width able to index n values, never narrower than one bit.
    function automatic int pw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Run-cycle counter: synchronous clear-to-1, count enable, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = W'(1);
        else if (en_i && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_run_sequencer.sv
// Batch launcher: resets, starts and times the DUT once per program image.
// Optional watchdog on the WAIT phase is enabled with SEQ_WATCHDOG_EN.
module prog_run_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PROGS    = 3,
    parameter int RESET_CYCLES = 2,
    parameter int START_CYCLES = 1,
    parameter int CYCLE_W      = 32,
    parameter int TIMEOUT      = 100000,
    localparam int PW          = pw_of(NUM_PROGS)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Go,
    input  logic               Abort,
    input  logic               DutAck,
    output logic               DutReset,
    output logic               DutStart,
    output logic [PW-1:0]      ProgSel,
    output logic               Busy,
    output logic               Done,
    output logic               Timeout,
    output logic               ResValid,
    output logic [PW-1:0]      ResProg,
    output logic [CYCLE_W-1:0] ResCycles
);

    localparam int PH_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
    localparam int PH_W   = pw_of(PH_MAX + 1);
    localparam logic [PH_W-1:0] RESET_LD = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0] START_LD = PH_W'(START_CYCLES - 1);
    localparam logic [PW-1:0]   LAST_PROG = PW'(NUM_PROGS - 1);

    seq_state_t state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;

    logic               dut_reset_q, dut_reset_d;
    logic               dut_start_q, dut_start_d;
    logic [PW-1:0]      prog_sel_q, prog_sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               res_valid_q, res_valid_d;
    logic [PW-1:0]      res_prog_q, res_prog_d;
    logic [CYCLE_W-1:0] res_cycles_q, res_cycles_d;

    logic [CYCLE_W-1:0] run_cnt;
    logic               cnt_clr, cnt_en;
    logic               ack_ev, last_run, wd_fire;

    // Ack only counts in WAIT so a level left over from the previous run is harmless.
    assign ack_ev   = (state_q == WAIT) && DutAck;
    assign last_run = (prog_sel_q == LAST_PROG);

`ifdef SEQ_WATCHDOG_EN
    localparam logic [CYCLE_W-1:0] TO_VAL = CYCLE_W'(TIMEOUT);
    assign wd_fire = (state_q == WAIT) && !DutAck && (run_cnt == TO_VAL);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign wd_fire        = 1'b0;
`endif

    // Counter reads 1 in the first START cycle and advances through START/WAIT.
    assign cnt_clr = (state_q == RST_HOLD) && (state_d == START);
    assign cnt_en  = (state_q == START) || (state_q == WAIT);

    sat_counter #(.W(CYCLE_W)) u_run_cnt (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (run_cnt)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            dut_reset_q  <= 1'b1;
            dut_start_q  <= 1'b0;
            prog_sel_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_prog_q   <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            dut_reset_q  <= dut_reset_d;
            dut_start_q  <= dut_start_d;
            prog_sel_q   <= prog_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            res_valid_q  <= res_valid_d;
            res_prog_q   <= res_prog_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (Go) state_d = RST_HOLD;
            RST_HOLD: if (phase_q == '0) state_d = START;
            START:    if (phase_q == '0) state_d = WAIT;
            WAIT: begin
                if (ack_ev)
                    state_d = last_run ? IDLE : RST_HOLD;
                else if (wd_fire)
                    state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        if (Abort)
            state_d = IDLE;

        // Phase down-counter reloads on entry to each timed phase.
        phase_d = (phase_q != '0) ? phase_q - PH_W'(1) : phase_q;
        if ((state_d == RST_HOLD) && (state_q != RST_HOLD))
            phase_d = RESET_LD;
        else if ((state_d == START) && (state_q != START))
            phase_d = START_LD;
    end

    always_comb begin
        dut_reset_d  = !((state_d == START) || (state_d == WAIT));
        dut_start_d  = (state_d == START);
        busy_d       = (state_d != IDLE);
        prog_sel_d   = prog_sel_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        res_valid_d  = 1'b0;
        res_prog_d   = res_prog_q;
        res_cycles_d = res_cycles_q;

        if (Abort) begin
            done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Go) begin
                        prog_sel_d = '0;
                        done_d     = 1'b0;
                        timeout_d  = 1'b0;
                    end
                end
                WAIT: begin
                    if (ack_ev || wd_fire) begin
                        res_valid_d  = 1'b1;
                        res_prog_d   = prog_sel_q;
                        res_cycles_d = run_cnt;
                    end
                    if (ack_ev) begin
                        if (last_run)
                            done_d = 1'b1;
                        else
                            prog_sel_d = prog_sel_q + PW'(1);
                    end else if (wd_fire) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DutReset  = dut_reset_q;
    assign DutStart  = dut_start_q;
    assign ProgSel   = prog_sel_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Timeout   = timeout_q;
    assign ResValid  = res_valid_q;
    assign ResProg   = res_prog_q;
    assign ResCycles = res_cycles_q;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Randomized scoreboard bench for prog_run_sequencer (2 programs, 2 reset, 1 start cycle).
module tb_prog_run_sequencer;

    localparam int NP = 2;
    localparam int RC = 2;
    localparam int SC = 1;
    localparam int CW = 16;
    localparam int TO = 20;

    logic          Clk = 1'b0;
    logic          Reset, Go, Abort, DutAck;
    logic          DutReset, DutStart, Busy, Done, Timeout, ResValid;
    logic [0:0]    ProgSel, ResProg;
    logic [CW-1:0] ResCycles;

    typedef struct {
        int prog;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    prog_run_sequencer #(
        .NUM_PROGS(NP), .RESET_CYCLES(RC), .START_CYCLES(SC), .CYCLE_W(CW), .TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Abort(Abort), .DutAck(DutAck),
        .DutReset(DutReset), .DutStart(DutStart), .ProgSel(ProgSel), .Busy(Busy),
        .Done(Done), .Timeout(Timeout), .ResValid(ResValid), .ResProg(ResProg),
        .ResCycles(ResCycles)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_total++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Scoreboard monitor: every result beat must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (ResValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result", $sformatf("got ResValid=1 ResCycles=%0d expected no beat", ResCycles));
                end else begin
                    e = exp_q.pop_front();
                    check("res_prog", 32'(ResProg), 32'(e.prog));
                    check("res_cycles", 32'(ResCycles), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    // Waits (bounded) for the first START cycle; counts DutReset-high cycles before it.
    task automatic wait_start(input bit ack_noise, output bit ok, output int rst_cnt);
        ok = 1'b1;
        rst_cnt = 0;
        for (int t = 0; DutStart !== 1'b1; t++) begin
            if (t > 50) begin
                fail_now("wait_start", "got no DutStart within 50 cycles expected DutStart=1");
                ok = 1'b0;
                break;
            end
            if (DutReset === 1'b1) rst_cnt++;
            if (ack_noise) DutAck = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
    endtask

    // One full batch. The model: result for program p carries SC + k, where
    // Ack is first seen on the k-th cycle after DutStart drops.
    task automatic run_batch(input bit stale, input bit noise);
        int   k, rc;
        bit   ok;
        exp_t e;
        Go = 1'b1;
        DutAck = stale;
        @(negedge Clk);
        Go = 1'b0;
        check("busy_after_go", 32'(Busy), 1);
        check("done_cleared", 32'(Done), 0);
        for (int p = 0; p < NP; p++) begin
            wait_start(noise && !stale, ok, rc);
            if (!ok) return;
            check("rst_hold_len", rc, RC);
            check("prog_sel", 32'(ProgSel), p);
            k = stale ? 1 : $urandom_range(1, 8);
            e.prog = p;
            e.cyc  = SC + k;
            exp_q.push_back(e);
            for (int c = 1; c <= SC + k; c++) begin
                check("start_level", 32'(DutStart), 32'(c <= SC));
                check("reset_low", 32'(DutReset), 0);
                if (noise) Go = 1'($urandom_range(0, 1));
                if (c == SC + k) DutAck = 1'b1;
                else if (!stale) DutAck = (c <= SC && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (c < SC + k) @(negedge Clk);
            end
            @(negedge Clk);
            Go = 1'b0;
            if (!stale) DutAck = 1'b0;
        end
        check("done_set", 32'(Done), 1);
        check("busy_clear", 32'(Busy), 0);
        check("dutreset_idle", 32'(DutReset), 1);
        DutAck = 1'b0;
    endtask

    initial begin
        int rc;
        bit ok;
        exp_t e;
        Reset = 1'b1; Go = 1'b0; Abort = 1'b0; DutAck = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_dutreset", 32'(DutReset), 1);
        check("rst_dutstart", 32'(DutStart), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_timeout", 32'(Timeout), 0);
        check("rst_resvalid", 32'(ResValid), 0);
        check("rst_progsel", 32'(ProgSel), 0);
        check("rst_resprog", 32'(ResProg), 0);
        check("rst_rescycles", 32'(ResCycles), 0);
        Reset = 1'b0;
        @(negedge Clk);

        run_batch(1'b0, 1'b0);
        repeat (3) @(negedge Clk);
        check("done_sticky", 32'(Done), 1);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("abort_clears_done", 32'(Done), 0);

        run_batch(1'b1, 1'b0);
        repeat (4) run_batch(1'b0, 1'b1);

        // Abort in WAIT with a simultaneous Ack: no result, back to IDLE.
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        wait_start(1'b0, ok, rc);
        repeat (2) @(negedge Clk);
        DutAck = 1'b1;
        Abort = 1'b1;
        @(negedge Clk);
        DutAck = 1'b0;
        Abort = 1'b0;
        check("abort_busy", 32'(Busy), 0);
        check("abort_done", 32'(Done), 0);
        check("abort_dutreset", 32'(DutReset), 1);
        check("abort_dutstart", 32'(DutStart), 0);
        check("abort_resvalid", 32'(ResValid), 0);

        // Go together with Abort in IDLE must not launch.
        Go = 1'b1;
        Abort = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        Abort = 1'b0;
        check("goabort_busy", 32'(Busy), 0);
        repeat (4) @(negedge Clk);
        check("goabort_nostart", 32'(DutStart), 0);
        check("goabort_dutreset", 32'(DutReset), 1);

        // Asynchronous reset in the middle of a run.
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        wait_start(1'b0, ok, rc);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("midrst_dutreset", 32'(DutReset), 1);
        check("midrst_busy", 32'(Busy), 0);
        check("midrst_dutstart", 32'(DutStart), 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

`ifdef SEQ_WATCHDOG_EN
        e.prog = 0;
        e.cyc  = TO;
        exp_q.push_back(e);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        for (int t = 0; Busy === 1'b1; t++) begin
            if (t > 100) begin
                fail_now("watchdog_wait", "got Busy=1 after 100 cycles expected Busy=0");
                break;
            end
            @(negedge Clk);
        end
        check("wd_timeout", 32'(Timeout), 1);
        check("wd_done", 32'(Done), 1);
        check("wd_busy", 32'(Busy), 0);
`else
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        repeat (1000) @(negedge Clk);
        check("nowd_busy", 32'(Busy), 1);
        check("nowd_timeout", 32'(Timeout), 0);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("nowd_abort_busy", 32'(Busy), 0);
`endif

        repeat (3) @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
